// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to memory over a
// read_en/ready handshake and hands each fetched word to the datapath over a
// valid/ready handshake. Redirects may arrive at any time; an in-flight read
// that cannot be cancelled is drained and its data dropped.
module instr_fetch #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read_en,
  input  logic [31:0]   mem_data_in,
  input  logic          mem_ready,
  output logic [31:0]   instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  output logic          misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,  // read in flight belongs to a stale PC; wait it out
    S_HOLD,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] req_addr, req_addr_n;
  logic [AW-1:0] instr_pc_n;
  logic [31:0]   instr_out_n;
  logic          instr_valid_n;
  logic          misaligned_n;

  // Request address is a register so it stays fixed for the whole read.
  assign mem_addr    = req_addr;
  assign mem_read_en = (state == S_FETCH) || (state == S_DRAIN);

  // State and datapath registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_addr    <= req_addr_n;
      instr_out   <= instr_out_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      misaligned  <= misaligned_n;
    end
  end

  // Next-state logic: redirects override normal sequencing except in FAULT.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    req_addr_n    = req_addr;
    instr_out_n   = instr_out;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    misaligned_n  = misaligned;

    if (state != S_FAULT && redirect_en) begin
      instr_valid_n = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misaligned_n = 1'b1;
        state_n      = S_FAULT;
      end else begin
        pc_n = redirect_pc;
        if ((state == S_FETCH || state == S_DRAIN) && !mem_ready) begin
          state_n = S_DRAIN;
        end else if (fetch_en) begin
          req_addr_n = redirect_pc;
          state_n    = S_FETCH;
        end else begin
          state_n = S_IDLE;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en) begin
            req_addr_n = pc;
            state_n    = S_FETCH;
          end
        end
        S_FETCH: begin
          // fetch_en is ignored here: a started read always completes.
          if (mem_ready) begin
            instr_out_n   = mem_data_in;
            instr_pc_n    = req_addr;
            instr_valid_n = 1'b1;
            pc_n          = req_addr + AW'(4);
            state_n       = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (mem_ready) begin
            req_addr_n = pc;
            state_n    = fetch_en ? S_FETCH : S_IDLE;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid_n = 1'b0;
            req_addr_n    = pc;
            state_n       = fetch_en ? S_FETCH : S_IDLE;
          end
        end
        S_FAULT: begin
          instr_valid_n = 1'b0;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, backpressure, drain on
// redirect, redirect on ready, redirect during HOLD, fetch_en drop, misaligned
// fault, and PC wrap from a top-of-memory reset PC.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory content: each word is its address tagged in the upper half.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- DUT 0: RESET_PC = 0 ----------------
  logic        rst, fetch_en, instr_ready, redirect_en;
  logic [31:0] redirect_pc;
  logic        auto_ready, man_ready;
  logic [31:0] mem_addr, mem_data_in, instr_out, instr_pc;
  logic        mem_read_en, mem_ready, instr_valid, misaligned;

  assign mem_ready   = auto_ready ? mem_read_en : man_ready;
  assign mem_data_in = word(mem_addr);

  instr_fetch #(.AW(32), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .misaligned(misaligned)
  );

  // ---------------- DUT 1: RESET_PC at top of memory ----------------
  logic        rst1, fetch_en1;
  logic [31:0] mem_addr1, instr_out1, instr_pc1;
  logic        mem_read_en1, instr_valid1, misaligned1;
  logic [31:0] mem_data_in1;
  logic        mem_ready1;

  assign mem_ready1   = mem_read_en1;
  assign mem_data_in1 = word(mem_addr1);

  instr_fetch #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst1), .fetch_en(fetch_en1),
    .mem_addr(mem_addr1), .mem_read_en(mem_read_en1),
    .mem_data_in(mem_data_in1), .mem_ready(mem_ready1),
    .instr_out(instr_out1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .instr_ready(1'b1), .redirect_en(1'b0),
    .redirect_pc(32'h0), .misaligned(misaligned1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect_en = 1'b0;
    redirect_pc = '0; auto_ready = 1'b0; man_ready = 1'b0;
    rst1 = 1'b1; fetch_en1 = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_read_en", {31'b0, mem_read_en}, 32'h0);
    chk("rst_valid",   {31'b0, instr_valid}, 32'h0);
    chk("rst_instr",   instr_out, 32'h0);
    chk("rst_ipc",     instr_pc, 32'h0);
    chk("rst_misal",   {31'b0, misaligned}, 32'h0);
    chk("rst_addr",    mem_addr, 32'h0);

    // Sequential fetch with zero-wait memory
    fetch_en = 1'b1; auto_ready = 1'b1; instr_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("seq_fetch_en", {31'b0, mem_read_en}, 32'h1);
      chk("seq_addr",     mem_addr, 32'(4 * k));
      chk("seq_novalid",  {31'b0, instr_valid}, 32'h0);
      step();
      chk("seq_valid",    {31'b0, instr_valid}, 32'h1);
      chk("seq_ipc",      instr_pc, 32'(4 * k));
      chk("seq_word",     instr_out, word(32'(4 * k)));
      chk("seq_hold_rd",  {31'b0, mem_read_en}, 32'h0);
      step();
    end
    // Now in FETCH at 0xC

    // Backpressure: held for 5 cycles
    instr_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", {31'b0, instr_valid}, 32'h1);
      chk("bp_ipc",   instr_pc, 32'hC);
      chk("bp_word",  instr_out, word(32'hC));
      chk("bp_rd",    {31'b0, mem_read_en}, 32'h0);
    end
    instr_ready = 1'b1; auto_ready = 1'b0; man_ready = 1'b0;
    step();
    chk("bp_next_addr", mem_addr, 32'h10);
    chk("bp_next_rd",   {31'b0, mem_read_en}, 32'h1);

    // Redirect to 0x40 while read at 0x10 is outstanding -> drain
    redirect_en = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_en = 1'b0;
    chk("drn_rd",    {31'b0, mem_read_en}, 32'h1);
    chk("drn_addr",  mem_addr, 32'h10);
    chk("drn_valid", {31'b0, instr_valid}, 32'h0);
    step();
    chk("drn_valid2", {31'b0, instr_valid}, 32'h0);
    step();
    man_ready = 1'b1;            // stale completion
    step();
    man_ready = 1'b0;
    chk("drn_new_addr", mem_addr, 32'h40);
    chk("drn_new_rd",   {31'b0, mem_read_en}, 32'h1);
    chk("drn_valid3",   {31'b0, instr_valid}, 32'h0);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("drn_ipc",  instr_pc, 32'h40);
    chk("drn_word", instr_out, word(32'h40));
    chk("drn_vld",  {31'b0, instr_valid}, 32'h1);

    // Redirect to 0x100 coincident with mem_ready in FETCH
    step();
    chk("rr_addr0", mem_addr, 32'h44);
    man_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    chk("rr_addr",  mem_addr, 32'h100);
    chk("rr_rd",    {31'b0, mem_read_en}, 32'h1);
    chk("rr_valid", {31'b0, instr_valid}, 32'h0);
    step();
    man_ready = 1'b0;
    chk("rr_ipc",  instr_pc, 32'h100);
    chk("rr_word", instr_out, word(32'h100));

    // Redirect and instr_ready in the same HOLD cycle: redirect wins
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    chk("hr_addr",  mem_addr, 32'h200);
    chk("hr_valid", {31'b0, instr_valid}, 32'h0);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("hr_ipc", instr_pc, 32'h200);

    // fetch_en drops during FETCH: read completes, HOLD, then IDLE
    step();
    chk("fe_addr", mem_addr, 32'h204);
    fetch_en = 1'b0;
    step();
    chk("fe_still_rd", {31'b0, mem_read_en}, 32'h1);
    chk("fe_addr2",    mem_addr, 32'h204);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("fe_ipc", instr_pc, 32'h204);
    step();
    chk("fe_idle_rd",  {31'b0, mem_read_en}, 32'h0);
    chk("fe_idle_vld", {31'b0, instr_valid}, 32'h0);
    step();
    chk("fe_idle_rd2", {31'b0, mem_read_en}, 32'h0);

    // Misaligned redirect -> sticky fault
    fetch_en = 1'b1;
    step();
    chk("mis_addr", mem_addr, 32'h208);
    redirect_en = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_en = 1'b0;
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    chk("mis_rd",   {31'b0, mem_read_en}, 32'h0);
    chk("mis_vld",  {31'b0, instr_valid}, 32'h0);
    man_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      man_ready = 1'b0;
      chk("mis_sticky", {31'b0, misaligned}, 32'h1);
      chk("mis_rd2",    {31'b0, mem_read_en}, 32'h0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_misal", {31'b0, misaligned}, 32'h0);
    chk("mr_rd",    {31'b0, mem_read_en}, 32'h0);
    chk("mr_vld",   {31'b0, instr_valid}, 32'h0);
    chk("mr_instr", instr_out, 32'h0);
    chk("mr_ipc",   instr_pc, 32'h0);
    chk("mr_addr",  mem_addr, 32'h0);

    // Park DUT 0, exercise PC wrap on DUT 1
    rst = 1'b1;
    rst1 = 1'b0;
    chk("w_rst_addr", mem_addr1, 32'hFFFF_FFFC);
    fetch_en1 = 1'b1;
    step();
    chk("w_addr0", mem_addr1, 32'hFFFF_FFFC);
    chk("w_rd0",   {31'b0, mem_read_en1}, 32'h1);
    step();
    chk("w_ipc0",  instr_pc1, 32'hFFFF_FFFC);
    chk("w_word0", instr_out1, word(32'hFFFF_FFFC));
    step();
    chk("w_addr1", mem_addr1, 32'h0);
    chk("w_rd1",   {31'b0, mem_read_en1}, 32'h1);
    rst1 = 1'b1;                 // reset while in FETCH
    step();
    chk("w_rst_rd",   {31'b0, mem_read_en1}, 32'h0);
    chk("w_rst_vld",  {31'b0, instr_valid1}, 32'h0);
    chk("w_rst_pc",   mem_addr1, 32'hFFFF_FFFC);
    chk("w_rst_mis",  {31'b0, misaligned1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
